parking_sensor_gen: RTL



---
 rtl/parking_pkg.sv | 48 ++++
 rtl/phase_timer.sv | 35 +++
 rtl/parking_sensor_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - state codes, direction values and a/b sensor patterns for parking_sensor_gen
package parking_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PH1  = 3'd1;
  localparam state_t ST_PH2  = 3'd2;
  localparam state_t ST_PH3  = 3'd3;
  localparam state_t ST_GAP  = 3'd4;

  localparam logic DIR_ENTER = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;

  // Patterns are {a, b}; consecutive phases differ in exactly one sensor.
  localparam logic [1:0] AB_IDLE   = 2'b00;
  localparam logic [1:0] ENTER_PH1 = 2'b10;
  localparam logic [1:0] ENTER_PH2 = 2'b11;
  localparam logic [1:0] ENTER_PH3 = 2'b01;
  localparam logic [1:0] EXIT_PH1  = 2'b01;
  localparam logic [1:0] EXIT_PH2  = 2'b11;
  localparam logic [1:0] EXIT_PH3  = 2'b10;

  function automatic logic [1:0] sensor_pattern(input state_t st, input logic dir);
    logic [1:0] ab;
    ab = AB_IDLE;
    case (st)
      ST_PH1:  ab = (dir == DIR_ENTER) ? ENTER_PH1 : EXIT_PH1;
      ST_PH2:  ab = (dir == DIR_ENTER) ? ENTER_PH2 : EXIT_PH2;
      ST_PH3:  ab = (dir == DIR_ENTER) ? ENTER_PH3 : EXIT_PH3;
      default: ab = AB_IDLE;
    endcase
    return ab;
  endfunction

  function automatic state_t prev_state(input state_t st);
    state_t p;
    p = ST_IDLE;
    case (st)
      ST_PH2:  p = ST_PH1;
      ST_PH3:  p = ST_PH2;
      ST_GAP:  p = ST_PH3;
      default: p = ST_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with an expired flag at zero
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_next_o,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;
  assign expired_o  = (cnt_q == '0);

endmodule

// File: rtl/parking_sensor_gen.sv
// rtl/parking_sensor_gen.sv - turns enter/exit requests into the a/b sensor waveform of a passing car
// Optional contact bounce at phase starts: define PARKING_BOUNCE_EN.
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int PHASE_CYCLES  = 16,
  parameter int GAP_CYCLES    = 8,
  parameter int BOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_dir,
  output logic       req_ready,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [7:0] car_count
);

  localparam int MAX_LEN = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [1:0]    ab_q, ab_d;
  logic [7:0]    count_q, count_d;
  logic          load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] cnt_next;
  logic          expired;

  phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .cnt_next_o (cnt_next),
    .expired_o  (expired)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    count_d  = count_q;
    load     = 1'b0;
    load_val = PHASE_LOAD;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_PH1;
        dir_d   = req_dir;
        load    = 1'b1;
      end
      ST_PH1: if (expired) begin
        state_d = ST_PH2;
        load    = 1'b1;
      end
      ST_PH2: if (expired) begin
        state_d = ST_PH3;
        load    = 1'b1;
      end
      ST_PH3: if (expired) begin
        state_d  = ST_GAP;
        load     = 1'b1;
        load_val = GAP_LOAD;
      end
      ST_GAP: if (expired) begin
        state_d = ST_IDLE;
        count_d = count_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // a/b are registered from the next state so they change on the edge that enters a phase.
`ifdef PARKING_BOUNCE_EN
  logic [CW-1:0] len_m1, idx;
  always_comb begin
    ab_d   = sensor_pattern(state_d, dir_d);
    len_m1 = (state_d == ST_GAP) ? GAP_LOAD : PHASE_LOAD;
    idx    = len_m1 - cnt_next;
    if (state_d != ST_IDLE && idx < CW'(BOUNCE_CYCLES) && idx[0]) begin
      ab_d = sensor_pattern(prev_state(state_d), dir_d);
    end
  end
`else
  localparam int unused_bounce_cycles = BOUNCE_CYCLES;
  wire unused_cnt_next = ^cnt_next;
  assign ab_d = sensor_pattern(state_d, dir_d);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_EXIT;
      ab_q    <= AB_IDLE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      count_q <= count_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_GAP) && expired;
  assign car_count = count_q;

endmodule
